// File: rtl/hilo_muldiv_pkg.sv
//------------------------------------------------------------------------------
// Module   : hilo_muldiv_pkg
// Purpose  : Shared types and constants for the HI/LO multiply/divide unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hilo_muldiv_pkg;

    localparam int         c_ITER_COUNT = 32;
    localparam logic [4:0] c_LAST_CNT   = 5'(c_ITER_COUNT - 1);

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic word_t negate(input word_t v);
        return ~v + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
//------------------------------------------------------------------------------
// Module   : muldiv_iter
// Purpose  : One combinational shift-add (multiply) or restoring (divide) step.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_iter
    import hilo_muldiv_pkg::*;
(
    input  logic  i_op_div,
    input  word_t i_hi,
    input  word_t i_lo,
    input  word_t i_operand,
    output word_t o_hi,
    output word_t o_lo
);

    logic [32:0] w_sum;
    logic [32:0] w_trial;

    always_comb begin
        w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_operand} : 33'd0);
        // Partial remainder stays below the divisor, so bit 32 is a true borrow.
        w_trial = {i_hi, i_lo[31]} - {1'b0, i_operand};
        o_hi    = w_sum[32:1];
        o_lo    = {w_sum[0], i_lo[31:1]};
        if (i_op_div) begin
            if (w_trial[32]) begin
                o_hi = {i_hi[30:0], i_lo[31]};
                o_lo = {i_lo[30:0], 1'b0};
            end else begin
                o_hi = w_trial[31:0];
                o_lo = {i_lo[30:0], 1'b1};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv.sv
//------------------------------------------------------------------------------
// Module   : hilo_muldiv
// Purpose  : Iterative 32-bit multiply/divide unit owning the HI/LO registers.
//            Define MULDIV_SIGNED_EN to add signed MULT/DIV support.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hilo_muldiv
    import hilo_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_div,
    input  logic        op_signed,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        mfhi_req,
    input  logic        mflo_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_cnt;
    word_t      r_wk_hi;
    word_t      r_wk_lo;
    word_t      r_operand;
    logic       r_op_div;
    word_t      r_hi;
    word_t      r_lo;
    logic       r_done;

    word_t      w_step_hi;
    word_t      w_step_lo;
    word_t      w_mag_a;
    word_t      w_mag_b;
    logic       w_last;
    logic       w_fix_req;

`ifdef MULDIV_SIGNED_EN
    logic        r_fix;
    logic        r_neg_hi;
    logic        r_neg_lo;
    logic        w_sign_a;
    logic        w_sign_b;
    word_t       w_fix_hi;
    word_t       w_fix_lo;
    logic [63:0] w_prod_neg;

    assign w_sign_a   = op_signed & src_a[31];
    assign w_sign_b   = op_signed & src_b[31];
    assign w_mag_a    = w_sign_a ? negate(src_a) : src_a;
    assign w_mag_b    = w_sign_b ? negate(src_b) : src_b;
    assign w_fix_req  = r_fix;
    assign w_prod_neg = ~{r_wk_hi, r_wk_lo} + 64'd1;

    always_comb begin
        w_fix_hi = r_wk_hi;
        w_fix_lo = r_wk_lo;
        if (!r_op_div) begin
            if (r_neg_lo) begin
                {w_fix_hi, w_fix_lo} = w_prod_neg;
            end
        end else begin
            if (r_neg_hi) w_fix_hi = negate(r_wk_hi);
            if (r_neg_lo) w_fix_lo = negate(r_wk_lo);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fix    <= 1'b0;
            r_neg_hi <= 1'b0;
            r_neg_lo <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_fix    <= op_signed;
            // Remainder follows the dividend; a zero divisor leaves the quotient un-negated.
            r_neg_hi <= op_div ? w_sign_a : (w_sign_a ^ w_sign_b);
            r_neg_lo <= op_div ? ((w_sign_a ^ w_sign_b) & (src_b != 32'd0))
                               : (w_sign_a ^ w_sign_b);
        end
    end
`else
    logic w_unused_signed;

    assign w_unused_signed = op_signed;
    assign w_mag_a         = src_a;
    assign w_mag_b         = src_b;
    assign w_fix_req       = 1'b0;
`endif

    muldiv_iter u_iter (
        .i_op_div  (r_op_div),
        .i_hi      (r_wk_hi),
        .i_lo      (r_wk_lo),
        .i_operand (r_operand),
        .o_hi      (w_step_hi),
        .o_lo      (w_step_lo)
    );

    assign w_last = (r_state == ST_RUN) && (r_cnt == c_LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = w_fix_req ? ST_FIX : ST_IDLE;
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_wk_hi   <= '0;
            r_wk_lo   <= '0;
            r_operand <= '0;
            r_op_div  <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A start in the same cycle as a move wins; the move is dropped.
                    if (start) begin
                        r_cnt     <= '0;
                        r_op_div  <= op_div;
                        r_wk_hi   <= '0;
                        r_wk_lo   <= w_mag_a;
                        r_operand <= w_mag_b;
                    end else begin
                        if (mthi) r_hi <= src_a;
                        if (mtlo) r_lo <= src_a;
                    end
                end
                ST_RUN: begin
                    r_cnt   <= r_cnt + 5'd1;
                    r_wk_hi <= w_step_hi;
                    r_wk_lo <= w_step_lo;
                    if (w_last && !w_fix_req) begin
                        r_hi   <= w_step_hi;
                        r_lo   <= w_step_lo;
                        r_done <= 1'b1;
                    end
                end
`ifdef MULDIV_SIGNED_EN
                ST_FIX: begin
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_done <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign done  = r_done;
    assign busy  = (r_state != ST_IDLE);
    assign stall = busy & (start | mfhi_req | mflo_req | mthi | mtlo);

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
//------------------------------------------------------------------------------
// Module   : tb_hilo_muldiv
// Purpose  : Self-checking bench for hilo_muldiv against an arithmetic model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op_div = 1'b0;
    logic        op_signed = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        mfhi_req = 1'b0;
    logic        mflo_req = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int n_cmp = 0;
    int n_bad = 0;

    hilo_muldiv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_div    (op_div),
        .op_signed (op_signed),
        .src_a     (src_a),
        .src_b     (src_b),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .mfhi_req  (mfhi_req),
        .mflo_req  (mflo_req),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference result {HI, LO} straight from the arithmetic definition.
    function automatic logic [63:0] ref_result(input bit is_div, input bit sgn,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [63:0] res;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            if (sgn) res = 64'(sa * sb);
            else     res = {32'b0, a} * {32'b0, b};
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (sgn) begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end else begin
            res = {a % b, a / b};
        end
        return res;
    endfunction

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    int          m_cnt = 0;
    bit          m_done = 1'b0;
    bit          m_live = 1'b0;
    bit          m_sgn;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   = '0;
            m_lo   = '0;
            m_cnt  = 0;
            m_done = 1'b0;
            m_live = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1'b1;
                end
            end else if (start) begin
`ifdef MULDIV_SIGNED_EN
                m_sgn = op_signed;
`else
                m_sgn = 1'b0;
`endif
                {p_hi, p_lo} = ref_result(op_div, m_sgn, src_a, src_b);
                m_cnt = m_sgn ? 33 : 32;
            end else begin
                if (mthi) m_hi = src_a;
                if (mtlo) m_lo = src_a;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("hi",    64'(hi),    64'(m_hi));
            chk("lo",    64'(lo),    64'(m_lo));
            chk("busy",  64'(busy),  64'(m_cnt != 0));
            chk("done",  64'(done),  64'(m_done));
            chk("stall", 64'(stall),
                64'((m_cnt != 0) && (start || mfhi_req || mflo_req || mthi || mtlo)));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input bit d, input bit s, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op_div = d; op_signed = s; src_a = a; src_b = b;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            cyc();
            k++;
        end
        chk("wait_idle_timeout", 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 20));
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nb;
        int nd;
        int k;
        cyc(2);
        chk("reset_hi",    64'(hi),    64'd0);
        chk("reset_lo",    64'(lo),    64'd0);
        chk("reset_busy",  64'(busy),  64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        rst_n = 1'b1;
        cyc();

        // MULTU 4 x 5: busy exactly 32 cycles, one done pulse.
        launch(1'b0, 1'b0, 32'd4, 32'd5);
        nb = 0; nd = 0;
        for (int i = 0; i < 40; i++) begin
            nb += int'(busy);
            nd += int'(done);
            cyc();
        end
        chk("mul4x5_busy_cycles", 64'(nb), 64'd32);
        chk("mul4x5_done_pulses", 64'(nd), 64'd1);
        chk("mul4x5_hi", 64'(hi), 64'd0);
        chk("mul4x5_lo", 64'(lo), 64'd20);
        chk("model_mul4x5_lo", 64'(m_lo), 64'd20);

        launch(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        chk("mulmax_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        chk("mulmax_lo", 64'(lo), 64'd1);
        chk("model_mulmax_hi", 64'(m_hi), 64'h0000_0000_FFFF_FFFE);

        launch(1'b1, 1'b0, 32'd100, 32'd7);
        wait_idle();
        chk("div100_7_lo", 64'(lo), 64'd14);
        chk("div100_7_hi", 64'(hi), 64'd2);

        launch(1'b1, 1'b0, 32'd9, 32'd0);
        wait_idle();
        chk("div9_0_hi", 64'(hi), 64'd9);
        chk("div9_0_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
        chk("model_div9_0_lo", 64'(m_lo), 64'h0000_0000_FFFF_FFFF);

        // MFHI pending from cycle 5 of a multiply must stall until the new HI lands.
        mthi = 1'b1; src_a = 32'h0000_DEAD;
        cyc();
        mthi = 1'b0;
        launch(1'b0, 1'b0, 32'h8000_0001, 32'h0000_0010);
        cyc(4);
        mfhi_req = 1'b1;
        #1;
        chk("mfhi_stall_asserted", 64'(stall), 64'd1);
        k = 0;
        while (stall && k < 100) begin
            cyc();
            k++;
        end
        chk("mfhi_stall_timeout", 64'(stall), 64'd0);
        chk("mfhi_sees_new_hi", 64'(hi), 64'd8);
        mfhi_req = 1'b0;
        cyc();

        // Start while busy is ignored and stalled; held start launches afterwards.
        launch(1'b0, 1'b0, 32'd2, 32'd3);
        cyc(3);
        start = 1'b1; op_div = 1'b1; src_a = 32'd50; src_b = 32'd5;
        #1;
        chk("start_busy_stall", 64'(stall), 64'd1);
        k = 0;
        while (stall && k < 100) begin
            cyc();
            k++;
        end
        chk("start_busy_first_lo", 64'(lo), 64'd6);
        cyc();
        start = 1'b0;
        wait_idle();
        chk("start_busy_second_lo", 64'(lo), 64'd10);
        chk("start_busy_second_hi", 64'(hi), 64'd0);

        // Reset mid-divide abandons everything.
        mthi = 1'b1; src_a = 32'hA5A5_A5A5;
        cyc();
        mthi = 1'b0;
        chk("mthi_a5", 64'(hi), 64'h0000_0000_A5A5_A5A5);
        launch(1'b1, 1'b0, 32'd1000, 32'd3);
        cyc(9);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_hi",   64'(hi),   64'd0);
        chk("midrst_lo",   64'(lo),   64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        cyc();
        rst_n = 1'b1;
        launch(1'b0, 1'b0, 32'd3, 32'd3);
        wait_idle();
        chk("post_rst_mul3x3_lo", 64'(lo), 64'd9);

`ifdef MULDIV_SIGNED_EN
        launch(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            nb += int'(busy);
            cyc();
        end
        chk("sdiv_busy_cycles", 64'(nb), 64'd33);
        chk("sdiv_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        chk("sdiv_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
`endif

        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            op_div    = 1'($urandom);
            op_signed = 1'($urandom);
            src_a     = pick();
            src_b     = pick();
            mthi      = ($urandom_range(0, 5) == 0);
            mtlo      = ($urandom_range(0, 5) == 0);
            mfhi_req  = ($urandom_range(0, 5) == 0);
            mflo_req  = ($urandom_range(0, 5) == 0);
            cyc();
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; mfhi_req = 1'b0; mflo_req = 1'b0;
        wait_idle();
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 Parameters: none; all widths are fixed at 32 bits.
REQ-002 clk  in  1  rising-edge system clock shared with all pipeline registers.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request to launch a multiply or divide from EX, sampled at the rising edge.
REQ-005 op_div  in  1  operation select: 0 = multiply, 1 = divide.
REQ-006 op_signed  in  1  operation signedness: 1 = MULT/DIV, 0 = MULTU/DIVU.
REQ-007 src_a, src_b  in  32 each  multiplicand/dividend and multiplier/divisor.
REQ-008 mthi, mtlo  in  1 each  direct write of src_a into HI or LO.
REQ-009 mfhi_req, mflo_req  in  1 each  an MFHI/MFLO read of HI/LO is pending in EX.
REQ-010 hi, lo  out  32 each  architectural HI/LO registers, feeding the MFHI/MFLO write-back path.
REQ-011 busy  out  1  an iterative operation is in progress.
REQ-012 done  out  1  one-cycle pulse in the cycle after HI/LO receive a result.
REQ-013 stall  out  1  freeze request to the IF/ID/EX pipeline registers.

Function
REQ-014 States: IDLE, RUN, FIX; busy = 1 in RUN and FIX.
- FIX exists only when signed support is compiled in (REQ-027).
REQ-015 IDLE -> RUN on start = 1.
- src_a, src_b, op_div and op_signed are latched on that edge.
- The iteration counter is cleared to 0.
REQ-016 RUN performs one iteration per cycle, 32 iterations in total (counter 0..31).
- Multiply: shift-add, producing a 64-bit product.
- Divide: restoring, producing quotient and remainder.
REQ-017 The counter wraps from 31 to 0 on the edge that leaves RUN; there is no 33rd iteration.
REQ-018 Unsigned result: on the 32nd RUN edge, HI/LO are written and the FSM returns to IDLE.
- Multiply: HI = product[63:32], LO = product[31:0].
- Divide: HI = remainder, LO = quotient.
- done = 1 in the following cycle; result latency is 32 edges after the start edge.
REQ-019 Divide by zero gets no special-case logic: the natural restoring result SHALL be HI = dividend, LO = 32'hFFFF_FFFF, with the same latency as any other divide.
REQ-020 start while busy is not accepted.
- stall = busy & (start | mfhi_req | mflo_req | mthi | mtlo), combinational.
- Requesters hold their inputs until stall falls.
REQ-021 In IDLE:
- mthi writes HI <= src_a; mtlo writes LO <= src_a; both may occur in the same cycle.
- start and mthi/mtlo in the same cycle: start wins, and the move is dropped.
REQ-022 hi and lo hold their values except on a result write or an accepted mthi/mtlo.

Reset
REQ-023 rst_n low SHALL asynchronously force:
- FSM = IDLE, counter = 0;
- hi = 0, lo = 0;
- busy = 0, done = 0, stall = 0.
REQ-024 Reset asserted mid-operation SHALL abandon the operation with no partial HI/LO update.
REQ-025 Deassertion SHALL be observed synchronously; the first start is accepted on the first rising edge with rst_n high.

Configuration
REQ-026 Macro MULDIV_SIGNED_EN selects signed support.
REQ-027 With MULDIV_SIGNED_EN defined:
- Signed operands are converted to magnitudes at the start edge.
- After the 32nd RUN edge the FSM enters FIX for one cycle and negates results there.
- Product sign = sign(a) xor sign(b); quotient sign = sign(a) xor sign(b); remainder sign = sign(dividend).
- Signed latency is 33 edges after the start edge.
- Signed divide by zero: HI = dividend, LO = 32'hFFFF_FFFF, with no negation applied.
REQ-028 Without MULDIV_SIGNED_EN:
- op_signed is ignored, and every operation runs unsigned.
- The FIX state and the negation logic are absent.

Structure
REQ-029 The shared package SHALL hold:
- the FSM state enum;
- the iteration count constant (32);
- the 32-bit data word typedef.
REQ-030 The iteration datapath SHALL be one sub-module, muldiv_iter, computing one shift-add or restore step combinationally; hilo_muldiv holds all state.

Verification
REQ-031 MULTU 4 x 5 -> busy for 32 cycles, then HI = 0, LO = 20, and done pulses once.
REQ-032 MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> HI = 32'hFFFF_FFFE, LO = 32'h0000_0001.
REQ-033 DIVU 100 / 7 -> LO = 14, HI = 2; DIVU 9 / 0 -> HI = 9, LO = 32'hFFFF_FFFF.
REQ-034 Stall checks:
- mfhi_req asserted at cycle 5 of a multiply -> stall = 1 until done, then the MFHI read sees the new HI.
- start during busy -> ignored, with stall = 1.
REQ-035 rst_n pulsed low at cycle 10 of a divide, after mthi wrote 32'hA5A5_A5A5 -> HI = 0, LO = 0, busy = 0; a following MULTU 3 x 3 gives LO = 9.
REQ-036 Signed division, with MULDIV_SIGNED_EN defined: DIV -7 / 2 -> LO = 32'hFFFF_FFFD, HI = 32'hFFFF_FFFF, result after 33 edges.
